// File: rtl/cmp_arb_pkg.sv
// -----------------------------------------------------------------------------
// cmp_arb_pkg
// Shared definitions for the comparator-sharing arbiter:
//   - state_t   : arbiter FSM state encoding (IDLE / EVAL / DONE)
//   - NREQ_MIN / NREQ_MAX : supported requester-count range
//   - clog2     : index width helper (never returns less than 1)
// -----------------------------------------------------------------------------
package cmp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NREQ_MIN = 2;
    localparam int NREQ_MAX = 8;

    // Width of a binary index able to address n items; minimum 1 bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int unsigned i = 1; i < 31; i++) begin
            if ((32'd1 << i) < n) r = int'(i) + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mag_cmp.sv
// -----------------------------------------------------------------------------
// mag_cmp
// Unsigned magnitude comparator shared by the calculator's operation units.
// Ports:
//   a, b in  BITS : operands
//   lt   out 1    : a < b (unsigned)
// -----------------------------------------------------------------------------
module mag_cmp #(
    parameter int BITS = 8
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic            lt
);

    assign lt = (a < b);

endmodule

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Searches req starting at ptr and
// wrapping modulo NREQ; the first set bit wins.
// Ports:
//   req    in  NREQ : request vector
//   ptr    in  IW   : search start position (0..NREQ-1)
//   win    out NREQ : one-hot winner (all zero when req == 0)
//   win_id out IW   : binary index of the winner (0 when req == 0)
// -----------------------------------------------------------------------------
module rr_pick
    import cmp_arb_pkg::*;
#(
    parameter int  NREQ = 4,
    localparam int IW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic [IW-1:0]   win_id
);

    logic          found;
    logic [IW:0]   sum;
    logic [IW-1:0] pos;

    always_comb begin
        win    = '0;
        win_id = '0;
        found  = 1'b0;
        sum    = '0;
        pos    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            // ptr + k wraps at NREQ; one extra bit keeps the sum exact
            // before the conditional subtract.
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
            pos = sum[IW-1:0];
            if (!found && req[pos]) begin
                found       = 1'b1;
                win[pos]    = 1'b1;
                win_id      = pos;
            end
        end
    end

endmodule

// File: rtl/cmp_share_arb.sv
// -----------------------------------------------------------------------------
// cmp_share_arb
// Round-robin controller sharing one mag_cmp among NREQ requesters.
// A winner is chosen in IDLE, its operands are latched, the comparison is
// registered in EVAL and a one-cycle ack is presented in DONE. One result
// per three cycles under continuous load.
// Optional feature: define CMP_ARB_EQ_EN to add the registered eq output.
// Ports:
//   clk   in  1         : clock, rising edge
//   rst   in  1         : synchronous active-high reset
//   req   in  NREQ      : level requests, held until ack
//   a_in  in  NREQ*BITS : operand a, requester i at [i*BITS +: BITS]
//   b_in  in  NREQ*BITS : operand b, same packing
//   gnt   out NREQ      : one-hot owner of the comparator (EVAL cycle)
//   ack   out NREQ      : one-hot result-valid pulse (DONE cycle)
//   lt    out 1         : a < b of the last served request, held
//   busy  out 1         : FSM not in IDLE
//   eq    out 1         : a == b of the last served request (CMP_ARB_EQ_EN)
// -----------------------------------------------------------------------------
module cmp_share_arb
    import cmp_arb_pkg::*;
#(
    parameter int BITS = 8,
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*BITS-1:0] a_in,
    input  logic [NREQ*BITS-1:0] b_in,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      ack,
    output logic                 lt,
    output logic                 busy
`ifdef CMP_ARB_EQ_EN
    ,
    output logic                 eq
`endif
);

    localparam int IW = clog2(NREQ);

    if (NREQ < NREQ_MIN || NREQ > NREQ_MAX) begin : g_bad_nreq
        $error("cmp_share_arb: NREQ out of supported range");
    end

    state_t          state, state_n;
    logic [IW-1:0]   ptr, ptr_n;
    logic [IW-1:0]   id, id_n;
    logic [BITS-1:0] opa, opa_n;
    logic [BITS-1:0] opb, opb_n;
    logic [NREQ-1:0] gnt_n, ack_n;
    logic            lt_n;
    logic [NREQ-1:0] win;
    logic [IW-1:0]   win_id;
    logic            cmp_lt;
`ifdef CMP_ARB_EQ_EN
    logic            eq_n;
`endif

    // Unpacked views of the operand buses so the winner can be selected by
    // its binary index.
    logic [BITS-1:0] a_arr [NREQ];
    logic [BITS-1:0] b_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign a_arr[g] = a_in[g*BITS +: BITS];
        assign b_arr[g] = b_in[g*BITS +: BITS];
    end

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .win    (win),
        .win_id (win_id)
    );

    mag_cmp #(
        .BITS (BITS)
    ) u_cmp (
        .a  (opa),
        .b  (opb),
        .lt (cmp_lt)
    );

    assign busy = (state != IDLE);

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        id_n    = id;
        opa_n   = opa;
        opb_n   = opb;
        gnt_n   = gnt;
        ack_n   = '0;
        lt_n    = lt;
`ifdef CMP_ARB_EQ_EN
        eq_n    = eq;
`endif
        unique case (state)
            IDLE: begin
                if (|req) begin
                    opa_n   = a_arr[win_id];
                    opb_n   = b_arr[win_id];
                    id_n    = win_id;
                    gnt_n   = win;
                    state_n = EVAL;
                end
            end
            EVAL: begin
                lt_n    = cmp_lt;
`ifdef CMP_ARB_EQ_EN
                eq_n    = (opa == opb);
`endif
                gnt_n   = '0;
                // gnt already holds the one-hot form of id.
                ack_n   = gnt;
                state_n = DONE;
            end
            DONE: begin
                if (id == IW'(NREQ - 1)) ptr_n = '0;
                else                     ptr_n = id + 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            id    <= '0;
            opa   <= '0;
            opb   <= '0;
            gnt   <= '0;
            ack   <= '0;
            lt    <= 1'b0;
`ifdef CMP_ARB_EQ_EN
            eq    <= 1'b0;
`endif
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            id    <= id_n;
            opa   <= opa_n;
            opb   <= opb_n;
            gnt   <= gnt_n;
            ack   <= ack_n;
            lt    <= lt_n;
`ifdef CMP_ARB_EQ_EN
            eq    <= eq_n;
`endif
        end
    end

endmodule

// File: tb/tb_cmp_share_arb.sv
// -----------------------------------------------------------------------------
// tb_cmp_share_arb
// Scoreboard bench for cmp_share_arb. A transaction-level model decides at
// each clock edge whether the arbiter is free (three cycles after the last
// grant), picks the round-robin winner from its own pointer and queues the
// expected ack. A monitor on the falling edge pops and compares acks and
// checks gnt/busy/lt against the model's timestamps.
// -----------------------------------------------------------------------------
module tb_cmp_share_arb;

    localparam int BITS = 8;
    localparam int NREQ = 4;

    logic                 clk  = 1'b0;
    logic                 rst  = 1'b1;
    logic [NREQ-1:0]      req  = '0;
    logic [NREQ*BITS-1:0] a_in = '0;
    logic [NREQ*BITS-1:0] b_in = '0;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      ack;
    logic                 lt;
    logic                 busy;
`ifdef CMP_ARB_EQ_EN
    logic                 eq;
`endif

    always #5 clk = ~clk;

    cmp_share_arb #(
        .BITS (BITS),
        .NREQ (NREQ)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .a_in (a_in),
        .b_in (b_in),
        .gnt  (gnt),
        .ack  (ack),
        .lt   (lt),
        .busy (busy)
`ifdef CMP_ARB_EQ_EN
        ,
        .eq   (eq)
`endif
    );

    typedef struct {
        int id;
        bit lt;
        bit eq;
        int due;
    } exp_t;

    exp_t sb[$];

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int ptr_m   = 0;
    int t_last  = -100;
    int cur_id  = 0;
    bit pend_lt = 1'b0;
    bit pend_eq = 1'b0;
    bit lt_hold = 1'b0;
    bit eq_hold = 1'b0;
    logic [NREQ-1:0] sticky = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: evaluated on every rising edge from the inputs the
    // bench is driving.
    initial begin : model
        int w;
        logic [BITS-1:0] av, bv;
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                ptr_m   = 0;
                t_last  = -100;
                lt_hold = 1'b0;
                eq_hold = 1'b0;
                sb.delete();
            end else begin
                if (cyc == t_last + 1) begin
                    lt_hold = pend_lt;
                    eq_hold = pend_eq;
                end
                if (cyc >= t_last + 3 && req != '0) begin
                    w = -1;
                    for (int off = 0; off < NREQ; off++) begin
                        int i;
                        i = (ptr_m + off) % NREQ;
                        if (w < 0 && req[i]) w = i;
                    end
                    av      = a_in[w*BITS +: BITS];
                    bv      = b_in[w*BITS +: BITS];
                    pend_lt = (av < bv);
                    pend_eq = (av == bv);
                    t_last  = cyc;
                    cur_id  = w;
                    ptr_m   = (w + 1) % NREQ;
                    e.id    = w;
                    e.lt    = pend_lt;
                    e.eq    = pend_eq;
                    e.due   = cyc + 1;
                    sb.push_back(e);
                end
            end
        end
    end

    // Monitor: samples on the falling edge.
    initial begin : monitor
        exp_t e;
        logic [NREQ-1:0] exp_gnt;
        forever begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_ack id=%0d actual=none required_cycle=%0d cycle=%0d",
                         sb[0].id, sb[0].due, cyc);
                void'(sb.pop_front());
            end
            exp_gnt = (cyc == t_last) ? (NREQ'(1) << cur_id) : '0;
            chk("gnt", 32'(gnt), 32'(exp_gnt));
            chk("busy", 32'(busy), 32'((cyc == t_last) || (cyc == t_last + 1)));
            chk("lt_hold", 32'(lt), 32'(lt_hold));
`ifdef CMP_ARB_EQ_EN
            chk("eq_hold", 32'(eq), 32'(eq_hold));
`endif
            if (ack !== '0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack actual=%0h required=0 cycle=%0d", ack, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("ack_id", 32'(ack), 32'(NREQ'(1) << e.id));
                    chk("ack_lt", 32'(lt), 32'(e.lt));
                    chk("ack_time", 32'(cyc), 32'(e.due));
`ifdef CMP_ARB_EQ_EN
                    chk("ack_eq", 32'(eq), 32'(e.eq));
`endif
                end
            end
        end
    end

    // Requester behaviour: a served request is released once its ack is seen
    // (unless held on purpose to exercise re-request ranking).
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (ack[i] && !sticky[i]) req[i] = 1'b0;
        end
    endtask

    task automatic set_op(input int i, input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        a_in[i*BITS +: BITS] = a;
        b_in[i*BITS +: BITS] = b;
    endtask

    function automatic logic [BITS-1:0] rand_op();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return BITS'($urandom);
        endcase
    endfunction

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (req != '0 && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (req != '0) begin
            errors++;
            $display("FAIL drain_timeout actual_req=%0h required=0 cycle=%0d", req, cyc);
            req = '0;
        end
        repeat (4) step();
    endtask

    initial begin : driver
        logic [BITS-1:0] ra;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // Single request, then equal and greater operands.
        step();
        set_op(0, 8'd3, 8'd7);
        req = 4'b0001;
        drain(20);
        set_op(0, 8'hFF, 8'hFF);
        req[0] = 1'b1;
        drain(20);
        set_op(0, 8'd200, 8'd5);
        req[0] = 1'b1;
        drain(20);

        // All four from reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_op(i, rand_op(), rand_op());
        req = '1;
        drain(30);

        // Two requesters held continuously: service must alternate.
        sticky = 4'b1001;
        req    = 4'b1001;
        repeat (24) step();
        sticky = '0;
        drain(20);

        // Operand change after the grant must not affect the result.
        set_op(0, 8'd1, 8'd5);
        req = 4'b0001;
        step();
        a_in[7:0] = 8'd9;
        drain(20);

        // Move the pointer off zero, then reset in the middle of EVAL.
        set_op(2, 8'd4, 8'd4);
        req = 4'b0100;
        drain(20);
        set_op(3, 8'd10, 8'd20);
        req = 4'b1000;
        step();
        rst = 1'b1;
        req = 4'b1111;
        step();
        rst = 1'b0;
        drain(40);

        // Random traffic with operand scrambling, withdrawals and resets.
        for (int c = 0; c < 3000; c++) begin
            step();
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    ra = rand_op();
                    set_op(i, ra, ($urandom_range(0, 3) == 0) ? ra : rand_op());
                    req[i] = 1'b1;
                end else if ($urandom_range(0, 1) == 0) begin
                    set_op(i, rand_op(), rand_op());
                end
                if (req[i] && $urandom_range(0, 39) == 0) req[i] = 1'b0;
            end
        end
        rst = 1'b0;
        drain(60);
        repeat (4) step();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected actual=%0d required=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
